// File: rtl/thing_stream_tx.sv
// thing_stream_tx: transmitter end of the thing stream protocol.
// The host preloads a script of {pop count, character} entries. On start, the
// block wakes the receiver with ready_lifo and plays the script on thing_in
// without gaps. It stalls on ';' until done_thing and ends on '$' after done_fifo2.
// Optional macro THING_TX_CHECK_EN adds the receiver stack-occupancy model
// and the sticky err flag. Without it, err is tied low.
module thing_stream_tx #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic [3:0] load_num,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ready_lifo,
    output logic [7:0] thing_in,
    output logic [3:0] thing_num,
    input  logic       done_thing,
    input  logic       done_fifo2
);

    localparam logic [7:0] CH_SEMI   = 8'd59;
    localparam logic [7:0] CH_DOLLAR = 8'd36;

    typedef enum logic [2:0] {IDLE, KICK, SEND, WAIT_LIFO, WAIT_FIFO} state_t;

    state_t      state, state_nx;
    logic [11:0] script [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW-1:0] rd_idx;
    logic [7:0]  cur_char;
    logic [3:0]  cur_num;
    logic [3:0]  num_q;
    logic        done_q;
    logic        exhausted, load_fire, start_fire, send_semi, fifo_done;

    assign rd_idx              = rd_ptr[AW-1:0];
    assign {cur_num, cur_char} = script[rd_idx];
    assign exhausted           = (rd_ptr == wr_ptr);
    assign load_ready          = (state == IDLE) && (wr_ptr != (AW+1)'(DEPTH));
    assign load_fire           = load_valid && load_ready;
    // start is judged against the pointer from before any same-cycle write
    assign start_fire          = (state == IDLE) && start && (wr_ptr != '0);
    assign fifo_done           = (state == WAIT_FIFO) && done_fifo2;
    assign busy                = (state != IDLE);
    assign done                = done_q;
    // the pop count shows up together with the ';' and is held afterwards
    assign thing_num           = send_semi ? cur_num : num_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and stream outputs
    always_comb begin
        state_nx   = state;
        thing_in   = 8'd0;
        ready_lifo = 1'b0;
        send_semi  = 1'b0;
        case (state)
            IDLE:      if (start_fire) state_nx = KICK;
            KICK: begin
                ready_lifo = 1'b1;
                state_nx   = SEND;
            end
            SEND: begin
                if (exhausted) begin
                    // script ran out without a terminator: close the stream ourselves
                    thing_in = CH_DOLLAR;
                    state_nx = WAIT_FIFO;
                end else begin
                    thing_in = cur_char;
                    if (cur_char == CH_SEMI) begin
                        send_semi = 1'b1;
                        state_nx  = WAIT_LIFO;
                    end else if (cur_char == CH_DOLLAR) begin
                        state_nx = WAIT_FIFO;
                    end
                end
            end
            WAIT_LIFO: if (done_thing) state_nx = SEND;
            WAIT_FIFO: if (done_fifo2) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // script storage write port; contents are invalidated by wr_ptr, not cleared
    always_ff @(posedge clk) begin
        if (load_fire) script[wr_ptr[AW-1:0]] <= {load_num, load_data};
    end

    // pointers, held pop count and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            num_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= fifo_done;
            if (fifo_done)      wr_ptr <= '0;
            else if (load_fire) wr_ptr <= wr_ptr + 1'b1;
            if (start_fire)           rd_ptr <= '0;
            else if (state == SEND)   rd_ptr <= rd_ptr + 1'b1;
            if (send_semi) num_q <= cur_num;
        end
    end

`ifdef THING_TX_CHECK_EN
    logic [4:0] occ;
    logic       err_q;
    logic       send_data;

    assign send_data = (state == SEND) && !exhausted &&
                       (cur_char != CH_SEMI) && (cur_char != CH_DOLLAR);
    assign err       = err_q;

    // receiver stack occupancy model; err flags wrap and pop underflow
    always_ff @(posedge clk) begin
        if (rst || start_fire) begin
            occ   <= 5'd0;
            err_q <= 1'b0;
        end else if (send_data) begin
            if (occ == 5'd16) err_q <= 1'b1;
            if (occ != 5'd31) occ   <= occ + 5'd1;
        end else if (send_semi) begin
            if ({1'b0, cur_num} > occ) begin
                err_q <= 1'b1;
                occ   <= 5'd0;
            end else begin
                occ <= occ - {1'b0, cur_num};
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/thing_stream_tx.md
Name: thing_stream_tx

Overview:
Transmitter end of the thing stream protocol. The host preloads a script of characters, each with a per-entry pop count. On start, the block wakes the stack/queue receiver with ready_lifo and then plays the script on thing_in with no gaps.
- On each ';' it presents the pop count on thing_num and holds until the receiver reports done_thing.
- On '$' it waits for done_fifo2, then returns to idle.

Parameters:
DEPTH, 64, number of script entries
AW, 6, script address width (log2 DEPTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
load_valid  input  1  host script write strobe
load_ready  output  1  script accepts a write (idle and not full)
load_data  input  8  script character
load_num  input  4  pop count (used only on ';' entries)
start  input  1  begin playback (sampled in IDLE)
busy  output  1  playback in progress
done  output  1  one-cycle pulse when playback completes
err  output  1  sticky protocol-violation flag
ready_lifo  output  1  receiver wake-up pulse
thing_in  output  8  character to receiver
thing_num  output  4  pop count to receiver
done_thing  input  1  receiver finished current LIFO pop group
done_fifo2  input  1  receiver finished FIFO drain

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 except load_ready=1. Script write/read pointers = 0. State = IDLE. Occupancy = 0.
- Script storage: DEPTH x 12 bits holding {num, char}.
  - Write occurs when load_valid && load_ready. wr_ptr then increments.
  - load_ready = (state==IDLE) && (wr_ptr != DEPTH). Writes while busy or full are dropped.
- States and transitions:
  - IDLE -> KICK on start with wr_ptr != 0. start with an empty script is ignored. rd_ptr is cleared, err is cleared, occupancy is cleared.
  - KICK: ready_lifo=1 for exactly this cycle. Next state SEND.
  - SEND: thing_in = script[rd_ptr].char. rd_ptr increments every cycle. No bubbles are allowed, because the receiver writes every non-delimiter byte.
    - char == 8'd59 (';'): thing_num is registered from the entry's num in the same cycle thing_in=';' is driven. Next state WAIT_LIFO.
    - char == 8'd36 ('$'): next state WAIT_FIFO.
    - rd_ptr == wr_ptr (script exhausted without '$'): the block drives thing_in=8'd36 itself this cycle. Next state WAIT_FIFO.
  - WAIT_LIFO: thing_in=0 and thing_num is held. On done_thing=1, next state SEND. The next character is driven on the cycle after done_thing.
  - WAIT_FIFO: thing_in=0. On done_fifo2=1, next state IDLE, done=1 for one cycle, and wr_ptr is cleared so the script is consumed.
- thing_in = 0 in all states except SEND. thing_num keeps its last registered value until the next ';' or reset.
- busy = (state != IDLE).
- Occupancy (4-bit plus overflow): modelled depth of the receiver's 16-entry stack.
  - +1 per data character sent.
  - -num per ';'. num=0 pops nothing; the receiver emits '0'.
- Simultaneous start and load_valid in IDLE: the load is accepted. The start sees the wr_ptr value from before that write.
- rst asserted mid-playback: next cycle all outputs are at reset values and the script is discarded.

Optional Feature:
THING_TX_CHECK_EN
- Defined: err sets when a data character is sent with occupancy==16 (receiver pointer wrap). err also sets when ';' is sent with num > occupancy (pop underflow). err is sticky until the next accepted start; playback continues.
- Undefined: occupancy logic is absent and err is tied 0.

Test Plan:
- Load 'A','B',';'(num=2),'$'; start -> ready_lifo=1 for one cycle; thing_in A,B,';' on three consecutive cycles; thing_num=2 from the ';' cycle; thing_in=0 until done_thing; then '$'; done one cycle after done_fifo2; busy=0.
- Load 'X',';'(num=0),'Y','$'; pulse done_thing 1 cycle after ';' -> 'Y' driven on the very next cycle; thing_num stays 0 throughout.
- Load 'P','Q' only -> thing_in P, Q, then auto 8'd36; enters WAIT_FIFO.
- Load 'A',';'(num=3),'$' -> err=1 with THING_TX_CHECK_EN, err=0 without; stream unchanged; 17 data characters before ';' also sets err when the macro is defined.
- Fill DEPTH entries -> load_ready=0 and the 65th write is dropped; during busy load_ready=0; start with an empty script leaves busy=0.
- Assert rst two cycles into SEND -> next cycle thing_in=0, ready_lifo=0, busy=0, load_ready=1; a subsequent start with an empty script does nothing.
